enc32to5_seq: RTL



---
 rtl/enc_pkg.sv | 16 +
 rtl/prio_enc32to5.sv | 22 ++
 rtl/enc32to5_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the sequential 32-to-5 encoder.
//   ENC_N       : input vector width (power of two)
//   ENC_W       : index width, log2(ENC_N)
//   enc_state_e : encoder state machine encoding
package enc_pkg;

  localparam int unsigned ENC_N = 32;
  localparam int unsigned ENC_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_ZERO = 2'd2
  } enc_state_e;

endpackage : enc_pkg

// File: rtl/prio_enc32to5.sv
// Combinational lowest-set-bit finder.
//   vec : input vector
//   idx : position of the lowest set bit (0 when vec is zero)
//   any : vec has at least one bit set
module prio_enc32to5
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] vec,
  output logic [ENC_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = int'(ENC_N) - 1; i >= 0; i--) begin
      if (vec[i]) idx = ENC_W'(i);
    end
  end

endmodule : prio_enc32to5

// File: rtl/enc32to5_seq.sv
// Sequential 32-to-5 encoder: accepts a multi-hot vector and emits the index
// of every set bit, lowest first, one per output handshake; final beat flagged.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : vector handshake, in_vec is the multi-hot vector
//   out_valid/out_ready: index handshake, out_idx is the current index
//   out_last           : current beat is the final one for this vector
//   out_zero           : only with ENC32TO5_ZERO_FLAG_EN; beat for an all-zero vector
// Without ENC32TO5_ZERO_FLAG_EN an all-zero vector is consumed with no beat.
module enc32to5_seq
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ENC_N-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ENC_W-1:0] out_idx,
  output logic             out_last
`ifdef ENC32TO5_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  enc_state_e       state_q, state_d;
  logic [ENC_N-1:0] pending_q, pending_d;
  logic [ENC_N-1:0] pending_drop_low;
  logic [ENC_W-1:0] low_idx;
  logic             pending_any;

  prio_enc32to5 u_prio (
    .vec (pending_q),
    .idx (low_idx),
    .any (pending_any)
  );

  // pending with its lowest set bit cleared; zero means one bit is left.
  assign pending_drop_low = pending_q & (pending_q - ENC_N'(1));

  // State and pending-bit register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next state and outputs; outputs decode from registered state only.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
`ifdef ENC32TO5_ZERO_FLAG_EN
    out_zero  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_d = in_vec;
          if (in_vec != '0) begin
            state_d = ST_EMIT;
          end else begin
`ifdef ENC32TO5_ZERO_FLAG_EN
            state_d = ST_ZERO;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_EMIT: begin
        out_valid = pending_any;
        out_idx   = low_idx;
        out_last  = (pending_drop_low == '0);
        if (!pending_any) begin
          // Unreachable in normal operation; recover rather than hang.
          state_d = ST_IDLE;
        end else if (out_ready) begin
          pending_d = pending_drop_low;
          if (pending_drop_low == '0) state_d = ST_IDLE;
        end
      end
`ifdef ENC32TO5_ZERO_FLAG_EN
      ST_ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_zero  = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

endmodule : enc32to5_seq
